// File: rtl/pattern_tx_pkg.sv
// Shared definitions for the pattern transmitter and the sequence-detector FSM
// it feeds: state codes, default frame width and the len-port width helper.
package pattern_tx_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SEND = 2'b01,
    GAP  = 2'b10
  } state_e;

  // Width of a bit-count port able to hold the value WIDTH itself.
  function automatic int len_w(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/pattern_tx_if.sv
// Frame request / serial output bundle between a frame source and pattern_tx.
interface pattern_tx_if
  import pattern_tx_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  localparam int LW = len_w(WIDTH);

  logic             start;
  logic [WIDTH-1:0] data;
  logic [LW-1:0]    len;
  logic             x;
  logic             x_valid;
  logic             ready;
  logic             done;
  logic [1:0]       S;

  modport master (
    output start, data, len,
    input  x, x_valid, ready, done, S
  );

  modport slave (
    input  start, data, len,
    output x, x_valid, ready, done, S
  );

endinterface

// File: rtl/pattern_tx_piso_shift.sv
// Parallel-load, left-shift register with a down-counter of remaining bits.
// The register holds the bits still to be sent after the one currently on x,
// so head is always the next bit to present.
module piso_shift
  import pattern_tx_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int LW    = len_w(WIDTH)
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  input  logic [LW-1:0]    len,
  output logic             head,
  output logic             last
);

  logic [WIDTH-1:0] sh_q;
  logic [LW-1:0]    cnt_q;

  // Load the remaining frame bits and L-1, or advance one bit per shift.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      sh_q  <= '0;
      cnt_q <= '0;
    end else if (load) begin
      sh_q  <= din;
      cnt_q <= len - LW'(1);
    end else if (shift) begin
      sh_q  <= {sh_q[WIDTH-2:0], 1'b0};
      cnt_q <= cnt_q - LW'(1);
    end
  end

  assign head = sh_q[WIDTH-1];
  assign last = (cnt_q == '0);

endmodule

// File: rtl/pattern_tx.sv
// Serial pattern transmitter: accepts a frame of up to WIDTH bits and shifts
// it out MSB-first with registered x / x_valid / done outputs.
//
// state | meaning
// IDLE  | ready for a frame; start with len!=0 captures data/len
// SEND  | one frame bit on x per cycle
// GAP   | single cycle after the last bit, done pulses
module pattern_tx
  import pattern_tx_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input logic         CLK,
  input logic         RESET,
  pattern_tx_if.slave bus
);

  localparam int LW = len_w(WIDTH);

  state_e           state_q, state_d;
  logic [LW-1:0]    len_c;
  logic [WIDTH-1:0] frame_aligned;
  logic [WIDTH-1:0] frame_rest;
  logic             load, shift;
  logic             head, last;
  logic             x_d, xv_d, done_d;
  logic             x_q, xv_q, done_q;

  // Clamp len to WIDTH and left-align the frame so its first bit is the MSB;
  // bits above len drop off the top and can never reach x.
  always_comb begin
    len_c         = (bus.len > LW'(WIDTH)) ? LW'(WIDTH) : bus.len;
    frame_aligned = bus.data << (LW'(WIDTH) - len_c);
    frame_rest    = {frame_aligned[WIDTH-2:0], 1'b0};
  end

  piso_shift #(
    .WIDTH (WIDTH),
    .LW    (LW)
  ) u_piso (
    .CLK   (CLK),
    .RESET (RESET),
    .load  (load),
    .shift (shift),
    .din   (frame_rest),
    .len   (len_c),
    .head  (head),
    .last  (last)
  );

  // State register.
  always_ff @(posedge CLK) begin
    if (RESET) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state plus the values the output registers take at the next edge.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    shift   = 1'b0;
    x_d     = 1'b0;
    xv_d    = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start && (len_c != '0)) begin
          state_d = SEND;
          load    = 1'b1;
          x_d     = frame_aligned[WIDTH-1];
          xv_d    = 1'b1;
        end
      end
      SEND: begin
        if (last) begin
          state_d = GAP;
          done_d  = 1'b1;
        end else begin
          shift = 1'b1;
          x_d   = head;
          xv_d  = 1'b1;
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output registers; reset drops them so an aborted frame gives no done.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      x_q    <= 1'b0;
      xv_q   <= 1'b0;
      done_q <= 1'b0;
    end else begin
      x_q    <= x_d;
      xv_q   <= xv_d;
      done_q <= done_d;
    end
  end

  assign bus.x       = x_q;
  assign bus.x_valid = xv_q;
  assign bus.done    = done_q;
  assign bus.S       = state_q;
  assign bus.ready   = (state_q == IDLE);

endmodule

// File: tb/tb_pattern_tx.sv
// Bench for pattern_tx: a per-cycle trace model (queue of expected cycles)
// checked every cycle, plus hand-computed frame expectations.
module tb_pattern_tx;

  localparam int W  = 8;
  localparam int LW = $clog2(W) + 1;

  logic CLK;
  logic RESET;

  pattern_tx_if #(.WIDTH(W)) bus ();

  pattern_tx #(.WIDTH(W)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic       x;
    logic       xv;
    logic       done;
    logic [1:0] s;
  } ent_t;

  ent_t exp_q[$];

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Trace model: an accepted frame becomes L bit-cycles and one gap cycle;
  // an empty queue means the transmitter is idle.
  initial begin
    forever begin
      @(posedge CLK);
      if (RESET) begin
        exp_q.delete();
      end else if (exp_q.size() > 0) begin
        void'(exp_q.pop_front());
      end else if (bus.start && bus.len != 0) begin
        int l;
        ent_t e;
        l = (int'(bus.len) > W) ? W : int'(bus.len);
        for (int i = 0; i < l; i++) begin
          e.x = bus.data[l-1-i]; e.xv = 1'b1; e.done = 1'b0; e.s = 2'b01;
          exp_q.push_back(e);
        end
        e.x = 1'b0; e.xv = 1'b0; e.done = 1'b1; e.s = 2'b10;
        exp_q.push_back(e);
      end
    end
  end

  // Per-cycle compare against the model, away from the active edge.
  initial begin
    forever begin
      @(posedge CLK);
      #2;
      if (exp_q.size() == 0) begin
        check("x",       16'(bus.x),       16'd0);
        check("x_valid", 16'(bus.x_valid), 16'd0);
        check("done",    16'(bus.done),    16'd0);
        check("S",       16'(bus.S),       16'd0);
        check("ready",   16'(bus.ready),   16'd1);
      end else begin
        check("x",       16'(bus.x),       16'(exp_q[0].x));
        check("x_valid", 16'(bus.x_valid), 16'(exp_q[0].xv));
        check("done",    16'(bus.done),    16'(exp_q[0].done));
        check("S",       16'(bus.S),       16'(exp_q[0].s));
        check("ready",   16'(bus.ready),   16'd0);
      end
    end
  end

  task automatic step();
    @(negedge CLK);
  endtask

  task automatic req(input logic [W-1:0] d, input logic [LW-1:0] l);
    bus.start = 1'b1;
    bus.data  = d;
    bus.len   = l;
  endtask

  initial begin
    logic [7:0]  got;
    logic [11:0] p_x, p_xv, p_dn;
    int ones, act;

    RESET = 1'b1;
    bus.start = 1'b0;
    bus.data  = '0;
    bus.len   = '0;
    step(); step();
    check("reset_S",     16'(bus.S),     16'd0);
    check("reset_ready", 16'(bus.ready), 16'd1);
    RESET = 1'b0;
    step();

    // 8-bit frame B6
    req(8'b1011_0110, 4'd8);
    got = '0; ones = 0;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (k == 1) begin bus.start = 1'b0; bus.data = 8'hFF; bus.len = 4'd2; end
      if (k <= 8) begin got = {got[6:0], bus.x}; ones += int'(bus.x_valid); end
      if (k == 9)  check("b6_done_c9",   16'(bus.done),  16'd1);
      if (k == 10) check("b6_ready_c10", 16'(bus.ready), 16'd1);
    end
    check("b6_bits",   16'(got),  16'hB6);
    check("b6_xvalid", 16'(ones), 16'd8);

    // short frame: only the low 3 bits of FD
    req(8'hFD, 4'd3);
    got = '0;
    for (int k = 1; k <= 5; k++) begin
      step();
      if (k == 1) bus.start = 1'b0;
      if (k <= 3) got = {got[6:0], bus.x};
      if (k == 4) check("fd_done_c4", 16'(bus.done), 16'd1);
    end
    check("fd_bits", 16'(got), 16'h05);

    // len=0 is ignored
    req(8'hFF, 4'd0);
    act = 0;
    for (int k = 1; k <= 5; k++) begin
      step();
      act += int'(bus.S != 2'b00) + int'(bus.x_valid) + int'(bus.done);
    end
    bus.start = 1'b0;
    check("len0_activity", 16'(act), 16'd0);
    step();

    // len=12 clamps to 8; a start pulse during SEND is ignored
    req(8'hA5, 4'd12);
    got = '0;
    for (int k = 1; k <= 11; k++) begin
      step();
      if (k == 1) bus.start = 1'b0;
      if (k == 3) begin bus.start = 1'b1; bus.data = 8'h0F; bus.len = 4'd4; end
      if (k == 4) bus.start = 1'b0;
      if (k <= 8) got = {got[6:0], bus.x};
      if (k == 9)  check("a5_done_c9", 16'(bus.done), 16'd1);
      if (k == 10) check("a5_idle_c10", 16'(bus.S), 16'd0);
      if (k == 11) check("a5_no_restart", 16'(bus.x_valid), 16'd0);
    end
    check("a5_bits", 16'(got), 16'hA5);

    // one-bit frame
    req(8'h01, 4'd1);
    step(); bus.start = 1'b0;
    check("len1_x", 16'(bus.x), 16'd1);
    step();
    check("len1_done_c2", 16'(bus.done), 16'd1);
    step();

    // back-to-back frames with start held high
    req(8'h09, 4'd4);
    p_x = '0; p_xv = '0; p_dn = '0;
    for (int k = 1; k <= 12; k++) begin
      step();
      p_x  = {p_x[10:0],  bus.x};
      p_xv = {p_xv[10:0], bus.x_valid};
      p_dn = {p_dn[10:0], bus.done};
    end
    bus.start = 1'b0;
    check("b2b_x",     16'(p_x),  16'(12'b1001_00_1001_00));
    check("b2b_xv",    16'(p_xv), 16'(12'b1111_00_1111_00));
    check("b2b_done",  16'(p_dn), 16'(12'b0000_10_0000_10));
    step(); step();

    // reset mid-frame, then a fresh frame
    req(8'h5A, 4'd8);
    for (int k = 1; k <= 4; k++) begin
      step();
      if (k == 1) bus.start = 1'b0;
    end
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    check("rst_S",     16'(bus.S),       16'd0);
    check("rst_ready", 16'(bus.ready),   16'd1);
    check("rst_xv",    16'(bus.x_valid), 16'd0);
    check("rst_done",  16'(bus.done),    16'd0);
    act = 0;
    for (int k = 0; k < 6; k++) begin step(); act += int'(bus.done); end
    check("rst_no_done", 16'(act), 16'd0);
    req(8'h80, 4'd8);
    got = '0;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (k == 1) bus.start = 1'b0;
      if (k <= 8) got = {got[6:0], bus.x};
    end
    check("post_rst_bits", 16'(got), 16'h80);

    step(); step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pattern_tx.md
PATTERN_TX -- requirements
Module: pattern_tx

Interface
REQ-001 Parameter: WIDTH, default 8, maximum number of bits in one serial frame (range 2..16).
REQ-002 Port: CLK  input  1  single clock; all state changes on rising edge.
REQ-003 Port: RESET  input  1  synchronous, active-high reset.
REQ-004 Port: start  input  1  request to transmit one frame; sampled only in IDLE.
REQ-005 Port: data  input  WIDTH  frame pattern; the low len bits are transmitted.
REQ-006 Port: len  input  $clog2(WIDTH)+1  number of bits to send.
REQ-007 Port: x  output  1  serial bit stream, MSB-first, intended to drive the x input of the team's serial sequence-detector FSM.
REQ-008 Port: x_valid  output  1  high in every cycle that x carries a frame bit.
REQ-009 Port: ready  output  1  high only in IDLE; a frame is accepted when start and ready are both 1 at an edge.
REQ-010 Port: done  output  1  one-cycle pulse in the cycle after the last bit.
REQ-011 Port: S  output  2  current state code, for debug and bench observation.

Function
REQ-012 Three states SHALL exist: IDLE=2'b00, SEND=2'b01, GAP=2'b10; 2'b11 is illegal and SHALL return to IDLE on the next edge.
REQ-013 IDLE: on an edge with start=1 and len!=0, data and len SHALL be captured and the state SHALL go to SEND; otherwise the state SHALL remain IDLE.
REQ-014 A len value greater than WIDTH SHALL be clamped to WIDTH at capture; len=0 SHALL be ignored, with no state change and no output activity.
REQ-015 SEND: outputs are registered, so bit i (i=0..L-1, L=captured len) SHALL appear as x=data[L-1-i] with x_valid=1 in the (i+1)-th cycle after the accepting edge.
REQ-016 The bit counter SHALL count down from L-1; after the bit with count 0 the state SHALL go to GAP.
REQ-017 GAP SHALL last exactly one cycle, with done=1, x=0 and x_valid=0, then return to IDLE.
REQ-018 Outside SEND, x SHALL be 0 and x_valid SHALL be 0.
REQ-019 start, data and len SHALL be ignored in SEND and GAP; changes to data or len after capture SHALL NOT affect the frame in progress.
REQ-020 With start held high, frames SHALL repeat back-to-back with period L+2 cycles: L bits, one GAP cycle, one IDLE cycle.
REQ-021 ready SHALL equal (S==IDLE) and be combinationally derived from the state register only.

Reset
REQ-022 RESET=1 at an edge SHALL force IDLE, x=0, x_valid=0, done=0, ready=1, S=2'b00, and clear the counter and shift register; RESET has priority over start.
REQ-023 A reset during SEND SHALL abort the frame with no done pulse; the first bit of any later frame SHALL be the MSB of that new frame.

Structure
REQ-024 State encodings (IDLE/SEND/GAP) and the default WIDTH SHALL live in the shared package used with the sequence-detector FSM.
REQ-025 The parallel-load, left-shift register with its down-counter SHALL be a single sub-module named piso_shift; pattern_tx holds the FSM and output registers.

Verification
REQ-026 data=8'b1011_0110, len=8, start pulse: x=1,0,1,1,0,1,1,0 with x_valid=1 in cycles 1..8, done=1 in cycle 9, ready=1 in cycle 10.
REQ-027 data=8'hFD, len=3: x=1,0,1 in cycles 1..3, then done; upper data bits never appear on x.
REQ-028 len=0 with start=1 for 5 cycles: S stays 2'b00, x_valid=0, done=0 throughout.
REQ-029 len=12 with WIDTH=8, data=8'hA5: exactly 8 bits are sent (1,0,1,0,0,1,0,1); a start pulse during SEND is ignored.
REQ-030 start held high, len=4, data=4'b1001: x_valid pattern is 1111 0 0 repeating, and done pulses every 6 cycles.
REQ-031 RESET asserted in bit 4 of an 8-bit frame: the next cycle shows S=00, ready=1, x_valid=0 and no done pulse; a new frame with data=8'h80 sends 1 then seven 0s.
